// File: rtl/tm_pkg.sv
// Shared types, default-configuration widths and helpers for the multi-class
// Tsetlin-machine inference pipeline.
package tm_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RESULT = 2'd2
  } state_e;

  // Counter width for a modulo-n counter; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Widths for the default configuration. Instances compute their own from
  // their parameters with cnt_width().
  localparam int DEF_CLASSES   = 10;
  localparam int DEF_CLAUSES   = 2000;
  localparam int DEF_LA_CHUNKS = 49;
  localparam int CLS_W = cnt_width(DEF_CLASSES);
  localparam int CL_W  = cnt_width(DEF_CLAUSES);
  localparam int CH_W  = cnt_width(DEF_LA_CHUNKS);

  // Saturate a class sum into [-t, +t].
  function automatic int sat_clamp(input int acc, input int t);
    if (acc > t)  return t;
    if (acc < -t) return -t;
    return acc;
  endfunction

endpackage

// File: rtl/tm_clause_eval.sv
// Per-clause chunk reduction: accumulates the violation flag and the
// "any include bit set" flag across the chunks of one clause and produces the
// clause output combinationally on the clause's last chunk.
module tm_clause_eval #(
  parameter int                  CHUNK_W   = 32,
  parameter logic [CHUNK_W-1:0]  FILTER    = '1,
  parameter int                  EMPTY_OUT = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               xfer,
  input  logic               last_chunk,
  input  logic [CHUNK_W-1:0] ta_include,
  input  logic [CHUNK_W-1:0] literals,
  output logic               clause_out
);

  logic               fail_q;
  logic               any_inc_q;
  logic [CHUNK_W-1:0] mask;
  logic               fail_nxt;
  logic               any_inc_nxt;

  // Only the last chunk of a clause carries padding bits that must be ignored.
  assign mask        = last_chunk ? FILTER : {CHUNK_W{1'b1}};
  assign fail_nxt    = fail_q    | (|(ta_include & ~literals & mask));
  assign any_inc_nxt = any_inc_q | (|(ta_include & mask));

  // Clause output including the chunk being transferred now.
  always_comb begin
    clause_out = 1'b0;
    if (!fail_nxt) clause_out = any_inc_nxt ? 1'b1 : (EMPTY_OUT != 0);
  end

  // Flags track the clause in progress and restart at every clause boundary.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_q    <= 1'b0;
      any_inc_q <= 1'b0;
    end else if (clr || (xfer && last_chunk)) begin
      fail_q    <= 1'b0;
      any_inc_q <= 1'b0;
    end else if (xfer) begin
      fail_q    <= fail_nxt;
      any_inc_q <= any_inc_nxt;
    end
  end

endmodule

// File: rtl/tm_multiclass_infer.sv
// Multi-class Tsetlin-machine inference: streams include/literal chunks for all
// classes (class outermost, clause middle, chunk innermost), accumulates the
// polarity-weighted clause votes per class, clamps each class sum to
// [-THRESHOLD, +THRESHOLD] and returns the running argmax.
//
// Handshakes: a chunk moves when in_valid && in_ready in the same cycle;
// in_ready depends only on state and stop_flag, never on in_valid. The result
// is offered with out_valid, held stable with its data until the cycle where
// out_valid && out_ready, and never withdrawn before that.
module tm_multiclass_infer
  import tm_pkg::*;
#(
  parameter int          CLASSES   = DEF_CLASSES,
  parameter int          CLAUSES   = DEF_CLAUSES,
  parameter int          LA_CHUNKS = DEF_LA_CHUNKS,
  parameter int          CHUNK_W   = 32,
  parameter logic [31:0] FILTER    = 32'hFFFF_FFFF,
  parameter int          THRESHOLD = 128,
  parameter int          SUM_W     = 16,
  parameter int          EMPTY_OUT = 0
) (
  input  logic                       clk,
  input  logic                       rst_flag,
  input  logic                       start,
  input  logic                       stop_flag,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHUNK_W-1:0]         ta_include,
  input  logic [CHUNK_W-1:0]         literals,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(CLASSES)-1:0] out_class,
  output logic signed [SUM_W-1:0]    out_sum,
  output state_e                     dbg_state
);

  localparam int CLS_W_I = cnt_width(CLASSES);
  localparam int CL_W_I  = cnt_width(CLAUSES);
  localparam int CH_W_I  = cnt_width(LA_CHUNKS);

  state_e                      state;
  logic [CH_W_I-1:0]           chunk_cnt;
  logic [CL_W_I-1:0]           clause_cnt;
  logic [CLS_W_I-1:0]          class_cnt;
  logic signed [SUM_W-1:0]     acc;
  logic signed [SUM_W-1:0]     best_sum;
  logic [CLS_W_I-1:0]          best_idx;

  logic                        xfer;
  logic                        last_chunk;
  logic                        last_clause;
  logic                        last_class;
  logic                        clause_out;
  logic signed [SUM_W-1:0]     vote;
  logic signed [SUM_W-1:0]     acc_nxt;
  logic signed [SUM_W-1:0]     clamp_val;
  logic                        take;

  assign in_ready    = (state == RUN) && !stop_flag;
  assign busy        = (state != IDLE);
  assign dbg_state   = state;
  assign xfer        = in_valid && in_ready;
  assign last_chunk  = (chunk_cnt  == CH_W_I'(LA_CHUNKS - 1));
  assign last_clause = (clause_cnt == CL_W_I'(CLAUSES - 1));
  assign last_class  = (class_cnt  == CLS_W_I'(CLASSES - 1));

  // Even clauses vote for the class, odd clauses against it.
  assign vote      = $signed({{(SUM_W-1){1'b0}}, clause_out});
  assign acc_nxt   = clause_cnt[0] ? (acc - vote) : (acc + vote);
  assign clamp_val = SUM_W'(sat_clamp(int'(acc_nxt), THRESHOLD));
  // Strict comparison keeps the lower index on ties.
  assign take      = (class_cnt == '0) || (clamp_val > best_sum);

  tm_clause_eval #(
    .CHUNK_W   (CHUNK_W),
    .FILTER    (FILTER[CHUNK_W-1:0]),
    .EMPTY_OUT (EMPTY_OUT)
  ) u_clause_eval (
    .clk        (clk),
    .rst        (rst_flag),
    .clr        (state == IDLE && start),
    .xfer       (xfer),
    .last_chunk (last_chunk),
    .ta_include (ta_include),
    .literals   (literals),
    .clause_out (clause_out)
  );

  // Control FSM plus counters, class accumulator, argmax and result registers.
  always_ff @(posedge clk or posedge rst_flag) begin
    if (rst_flag) begin
      state      <= IDLE;
      chunk_cnt  <= '0;
      clause_cnt <= '0;
      class_cnt  <= '0;
      acc        <= '0;
      best_sum   <= '0;
      best_idx   <= '0;
      out_valid  <= 1'b0;
      out_class  <= '0;
      out_sum    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state      <= RUN;
            chunk_cnt  <= '0;
            clause_cnt <= '0;
            class_cnt  <= '0;
            acc        <= '0;
          end
        end
        RUN: begin
          if (xfer) begin
            if (!last_chunk) begin
              chunk_cnt <= chunk_cnt + 1'b1;
            end else begin
              chunk_cnt <= '0;
              if (!last_clause) begin
                clause_cnt <= clause_cnt + 1'b1;
                acc        <= acc_nxt;
              end else begin
                clause_cnt <= '0;
                acc        <= '0;
                if (take) begin
                  best_sum <= clamp_val;
                  best_idx <= class_cnt;
                end
                if (!last_class) begin
                  class_cnt <= class_cnt + 1'b1;
                end else begin
                  class_cnt <= '0;
                  state     <= RESULT;
                  out_valid <= 1'b1;
                  out_class <= take ? class_cnt : best_idx;
                  out_sum   <= take ? clamp_val : best_sum;
                end
              end
            end
          end
        end
        RESULT: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tm_multiclass_infer.sv
// Bench for tm_multiclass_infer with a small configuration: a reference model
// computes each inference result into an expected queue when the stimulus is
// prepared; the result collector pops and compares on each handshake.
module tb_tm_multiclass_infer;
  import tm_pkg::*;

  localparam int CLASSES   = 3;
  localparam int CLAUSES   = 4;
  localparam int LA_CHUNKS = 2;
  localparam int CHUNK_W   = 8;
  localparam int THRESHOLD = 2;
  localparam int SUM_W     = 16;
  localparam int EMPTY_OUT = 0;
  localparam logic [7:0] FILT = 8'h0F;
  localparam int TOTAL = CLASSES * CLAUSES * LA_CHUNKS;

  logic               clk = 1'b0;
  logic               rst_flag = 1'b1;
  logic               start = 1'b0;
  logic               stop_flag = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [CHUNK_W-1:0] ta_include = '0;
  logic [CHUNK_W-1:0] literals = '0;
  logic               busy;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [1:0]         out_class;
  logic signed [SUM_W-1:0] out_sum;
  state_e             dbg_state;

  logic [7:0]  inc_mem [CLASSES][CLAUSES][LA_CHUNKS];
  logic [7:0]  lit_mem [CLASSES][CLAUSES][LA_CHUNKS];
  logic [17:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  tm_multiclass_infer #(
    .CLASSES(CLASSES), .CLAUSES(CLAUSES), .LA_CHUNKS(LA_CHUNKS),
    .CHUNK_W(CHUNK_W), .FILTER(32'h0000_000F), .THRESHOLD(THRESHOLD),
    .SUM_W(SUM_W), .EMPTY_OUT(EMPTY_OUT)
  ) dut (
    .clk(clk), .rst_flag(rst_flag), .start(start), .stop_flag(stop_flag),
    .in_valid(in_valid), .in_ready(in_ready), .ta_include(ta_include),
    .literals(literals), .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready), .out_class(out_class), .out_sum(out_sum),
    .dbg_state(dbg_state)
  );

  // Clock and reset.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: push {class, sum} for the pattern currently in memory.
  task automatic model_push();
    int best, bi, acc, cl, o;
    logic fail, any;
    logic [7:0] m;
    best = 0; bi = 0;
    for (int c = 0; c < CLASSES; c++) begin
      acc = 0;
      for (int k = 0; k < CLAUSES; k++) begin
        fail = 0; any = 0;
        for (int h = 0; h < LA_CHUNKS; h++) begin
          m = (h == LA_CHUNKS - 1) ? FILT : 8'hFF;
          if ((inc_mem[c][k][h] & ~lit_mem[c][k][h] & m) != 0) fail = 1;
          if ((inc_mem[c][k][h] & m) != 0) any = 1;
        end
        o = fail ? 0 : (any ? 1 : EMPTY_OUT);
        acc = (k % 2 == 0) ? acc + o : acc - o;
      end
      cl = (acc > THRESHOLD) ? THRESHOLD : ((acc < -THRESHOLD) ? -THRESHOLD : acc);
      if (c == 0 || cl > best) begin
        best = cl; bi = c;
      end
    end
    exp_q.push_back({bi[1:0], best[15:0]});
  endtask

  task automatic clear_mem();
    for (int c = 0; c < CLASSES; c++)
      for (int k = 0; k < CLAUSES; k++)
        for (int h = 0; h < LA_CHUNKS; h++) begin
          inc_mem[c][k][h] = 8'h00;
          lit_mem[c][k][h] = 8'h00;
        end
  endtask

  task automatic rand_mem();
    for (int c = 0; c < CLASSES; c++)
      for (int k = 0; k < CLAUSES; k++)
        for (int h = 0; h < LA_CHUNKS; h++) begin
          inc_mem[c][k][h] = 8'($urandom & $urandom & $urandom);
          lit_mem[c][k][h] = 8'($urandom_range(255));
        end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_start", busy, 1);
    check("state_run", dbg_state, RUN);
  endtask

  // Driver: stream all chunks with optional gaps, a 5-cycle stop window and a
  // stray start pulse while running.
  task automatic drive_all(input int gap_pct, input int stop_at, input int start_at);
    int idx, cyc, c, k, h;
    logic xfer;
    idx = 0; cyc = 0;
    while (idx < TOTAL && cyc < 400) begin
      c = idx / (CLAUSES * LA_CHUNKS);
      k = (idx / LA_CHUNKS) % CLAUSES;
      h = idx % LA_CHUNKS;
      stop_flag  = (stop_at >= 0) && (cyc >= stop_at) && (cyc < stop_at + 5);
      start      = (cyc == start_at);
      in_valid   = ($urandom_range(99) >= gap_pct);
      ta_include = inc_mem[c][k][h];
      literals   = lit_mem[c][k][h];
      #1;
      if (stop_flag) check("stop_rdy", in_ready, 0);
      xfer = in_valid && in_ready;
      if (xfer && idx == TOTAL - 1) check("ov_pre", out_valid, 0);
      @(posedge clk); #1;
      if (xfer) idx++;
      cyc++;
    end
    in_valid = 0; stop_flag = 0; start = 0;
    if (idx < TOTAL) check("xfer_timeout", idx, TOTAL);
    else check("latency", out_valid, 1);
  endtask

  // Result collector: hold out_ready low for 'hold' cycles, then handshake
  // and compare against the head of the expected queue.
  task automatic collect(input int hold);
    int w;
    logic [17:0] got, exp;
    w = 0;
    while (!out_valid && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (!out_valid) begin
      check("ov_timeout", out_valid, 1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    got = {out_class, out_sum};
    out_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", out_valid, 1);
      check("hold_data", {out_class, out_sum}, got);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (exp_q.size() == 0) begin
      check("q_empty", 0, 1);
    end else begin
      exp = exp_q.pop_front();
      check("out_class", got[17:16], exp[17:16]);
      check("out_sum", got[15:0], exp[15:0]);
    end
    check("ov_clear", out_valid, 0);
    check("busy_clear", busy, 0);
  endtask

  task automatic run_inf(input int gap_pct, input int stop_at, input int start_at, input int hold);
    model_push();
    pulse_start();
    drive_all(gap_pct, stop_at, start_at);
    collect(hold);
    @(posedge clk); #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rdy"}, in_ready, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ov"}, out_valid, 0);
    check({tag, "_cls"}, out_class, 0);
    check({tag, "_sum"}, out_sum, 0);
    check({tag, "_st"}, dbg_state, IDLE);
  endtask

  task automatic pattern2();
    clear_mem();
    inc_mem[2][0][0] = 8'h01; lit_mem[2][0][0] = 8'h01;
    inc_mem[2][2][0] = 8'h01; lit_mem[2][2][0] = 8'h01;
  endtask

  task automatic pattern3();
    clear_mem();
    for (int k = 0; k < CLAUSES; k++) begin
      inc_mem[1][k][0] = 8'h10; lit_mem[1][k][0] = 8'h10;
      if (k % 2 == 1) begin
        inc_mem[0][k][1] = 8'h02; lit_mem[0][k][1] = 8'h02;
      end
    end
  endtask

  // Stimulus.
  initial begin
    logic [7:0] sv_inc [CLASSES][CLAUSES][LA_CHUNKS];
    logic [7:0] sv_lit [CLASSES][CLAUSES][LA_CHUNKS];
    clear_mem();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("rst");
    rst_flag = 1'b0;
    @(posedge clk); #1;

    // All includes empty: every sum 0, tie to class 0.
    clear_mem();
    run_inf(0, -1, -1, 0);

    // Class 2 wins with +2.
    pattern2();
    run_inf(0, -1, -1, 0);

    // Sums -2, 0, 0: class 1 wins with 0.
    pattern3();
    run_inf(0, -1, -1, 0);

    // FILTER masks bit 7 on the last chunk; bit 7 on chunk 0 still fails.
    clear_mem();
    inc_mem[0][0][1] = 8'h81; lit_mem[0][0][1] = 8'h01;
    inc_mem[1][0][0] = 8'h80; lit_mem[1][0][0] = 8'h00;
    inc_mem[1][0][1] = 8'h01; lit_mem[1][0][1] = 8'h01;
    inc_mem[1][2][0] = 8'h04; lit_mem[1][2][0] = 8'h04;
    run_inf(0, -1, -1, 0);

    // Same random pattern unstalled, then with gaps, stop window and stray start.
    rand_mem();
    sv_inc = inc_mem; sv_lit = lit_mem;
    run_inf(0, -1, -1, 0);
    inc_mem = sv_inc; lit_mem = sv_lit;
    run_inf(30, 6, 3, 0);

    // Consumer back-pressure.
    pattern2();
    run_inf(0, -1, -1, 4);

    // Reset in the middle of a run discards everything.
    pattern3();
    pulse_start();
    in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ta_include = inc_mem[0][i / 2][i % 2];
      literals   = lit_mem[0][i / 2][i % 2];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    #2 rst_flag = 1'b1;
    #1;
    check_idle_outputs("mid_rst");
    @(posedge clk); #1;
    rst_flag = 1'b0;
    @(posedge clk); #1;
    run_inf(0, -1, -1, 0);

    // A few random inferences with gaps and stalls.
    for (int r = 0; r < 4; r++) begin
      rand_mem();
      run_inf($urandom_range(40), $urandom_range(20), -1, $urandom_range(3));
    end

    if (exp_q.size() != 0) check("q_leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tm_multiclass_infer.md
Name: tm_multiclass_infer

Overview:
- Parametrised successor to the single-class TM pipeline.
- Streams include-mask and literal chunks for all classes, computes clause outputs, and accumulates polarity-weighted class sums with threshold clamping.
- Performs a running argmax and returns the winning class and its sum over a valid/ready handshake.
- Sits between the TA-state memory streamer and the system result collector.

Parameters:
- CLASSES, 10, number of classes evaluated per inference.
- CLAUSES, 2000, clauses per class; even index = positive polarity, odd = negative.
- LA_CHUNKS, 49, literal chunks per clause.
- CHUNK_W, 32, bits per literal/include chunk.
- FILTER, 32'hFFFFFFFF, valid-bit mask applied to the last chunk of each clause.
- THRESHOLD, 128, clamp bound T; class sum saturates to [-T, +T].
- SUM_W, 16, signed class-sum width; must hold CLAUSES and T.
- EMPTY_OUT, 0, output of a clause with no include bits set (0 = inference convention).

Ports:
- clk  in  1  clock.
- rst_flag  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse that begins an inference; honoured only in IDLE.
- stop_flag  in  1  pause; while high, in_ready=0 and all counters/accumulators freeze.
- in_valid  in  1  chunk pair valid.
- in_ready  out  1  block accepts a chunk this cycle.
- ta_include  in  CHUNK_W  include bits for the current chunk.
- literals  in  CHUNK_W  literal values (x and ~x pre-arranged upstream).
- busy  out  1  high from start acceptance until result handshake completes.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  result consumer ready.
- out_class  out  $clog2(CLASSES)  winning class index.
- out_sum  out  SUM_W signed  clamped sum of the winning class.

Behaviour:
- Reset (async, immediate): FSM=IDLE; all counters 0; accumulators 0; in_ready=0, busy=0, out_valid=0, out_class=0, out_sum=0. Reset mid-inference discards all partial state.
- FSM has three states: IDLE -> RUN on start; RUN -> RESULT on acceptance of the last chunk of the last clause of the last class; RESULT -> IDLE when out_valid && out_ready.
- in_ready = (state==RUN) && !stop_flag. A transfer occurs when in_valid && in_ready.
- Streaming order: class outermost, clause middle, chunk innermost. Counters chunk_cnt, clause_cnt and class_cnt wrap/advance on a transfer.
- Per transfer: mask = (chunk_cnt==LA_CHUNKS-1) ? FILTER[CHUNK_W-1:0] : all-ones.
  - fail |= |(ta_include & ~literals & mask).
  - any_inc |= |(ta_include & mask).
- Clause end (last chunk transfer): clause_out = fail_final ? 0 : (any_inc_final ? 1 : EMPTY_OUT), using values including the current chunk.
  - acc += clause_out for an even clause index; acc -= clause_out for odd.
  - fail and any_inc clear for the next clause.
- Class end (last clause): clamp = min(max(acc_final, -T), +T).
  - If class_cnt==0 or clamp > best_sum (strict): best_sum <= clamp, best_idx <= class_cnt. Ties go to the lower index.
  - acc clears.
- Result: out_valid rises the cycle after the final transfer, with out_class=best_idx and out_sum=best_sum. Outputs stay stable while out_valid && !out_ready.
- Latency: exactly 1 cycle from the final accepted chunk to out_valid; throughput 1 chunk/cycle when unstalled.
- start in RUN or RESULT is ignored. stop_flag in RESULT has no effect on the handshake.
- The accumulator needs no overflow handling when SUM_W >= $clog2(CLAUSES)+2. Saturation applies only at class end.
- busy = (state != IDLE).

Decomposition:
- Package tm_pkg holds these shared items:
  - state enum (IDLE/RUN/RESULT);
  - localparams CLS_W=$clog2(CLASSES), CL_W=$clog2(CLAUSES), CH_W=$clog2(LA_CHUNKS);
  - function sat_clamp(acc, T).
- One natural sub-module, tm_clause_eval, holds the per-clause chunk reduction (fail/any_inc registers, FILTER masking, clause_out). The top module keeps the FSM, counters, accumulator and argmax.

Test Plan:
Bench parameters: CLASSES=3, CLAUSES=4, LA_CHUNKS=2, CHUNK_W=8, FILTER=8'h0F, T=2.
1. All includes 0, EMPTY_OUT=0 -> all sums 0; out_class=0, out_sum=0 (tie resolves to lowest index).
2. Class 2: clauses 0 and 2 include a bit whose literal is 1; all other clauses empty -> sums 0, 0, +2; out_class=2, out_sum=2, out_valid exactly 1 cycle after the 24th transfer.
3. Class 1: all four clauses satisfied. Class 0: only odd clauses satisfied -> sums -2, 0, 0 (class 1's +2 -2 +2 -2 nets 0); out_class=1, out_sum=0.
4. Include bit 7 set on last chunk with literal 0 -> masked by FILTER, clause fires. Same bit on chunk 0 -> clause fails.
5. stop_flag high 5 cycles mid-clause and in_valid gaps -> in_ready=0 during stop; result identical to the unstalled run.
6. out_ready low 4 cycles -> out_valid and outputs held. Then rst_flag asserted mid-RUN -> immediate IDLE, outputs 0; a fresh start gives a correct result.
